// File: rtl/ahb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_if
// Description : Bundle of the AHB arbitration signals shared between the
//               managers/bus fabric and the arbiter.
//                 i_HBUSREQ   [N_MASTERS] per-manager bus request
//                 i_HLOCK     [N_MASTERS] per-manager locked-transfer request
//                 i_HTRANS    [2]         transfer type of address-phase owner
//                 i_HBURST    [3]         burst type of address-phase owner
//                 i_HREADY    [1]         bus-wide transfer complete
//                 o_HGRANT    [N_MASTERS] one-hot grant
//                 o_HMASTER   [IDX_W]     index of address-phase owner
//                 o_HMASTLOCK [1]         current address phase is locked
//               Modport "slave" is the arbiter's view, "master" the view of
//               whoever drives the requests and observes the grant.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2
);
  logic [N_MASTERS-1:0] i_HBUSREQ;
  logic [N_MASTERS-1:0] i_HLOCK;
  logic [1:0]           i_HTRANS;
  logic [2:0]           i_HBURST;
  logic                 i_HREADY;
  logic [N_MASTERS-1:0] o_HGRANT;
  logic [IDX_W-1:0]     o_HMASTER;
  logic                 o_HMASTLOCK;

  modport slave (
    input  i_HBUSREQ, i_HLOCK, i_HTRANS, i_HBURST, i_HREADY,
    output o_HGRANT, o_HMASTER, o_HMASTLOCK
  );

  modport master (
    output i_HBUSREQ, i_HLOCK, i_HTRANS, i_HBURST, i_HREADY,
    input  o_HGRANT, o_HMASTER, o_HMASTLOCK
  );
endinterface
`default_nettype wire

// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter
// Description : Round-robin AHB bus arbiter with burst-aware handover and
//               locked-transfer support.
//                 i_HCLK   : bus clock, all state changes on rising edge
//                 i_HRESET : synchronous active-high reset
//                 bus      : ahb_arbiter_if.slave (requests, locks, transfer
//                            type/burst, HREADY in; grant, owner, lock out)
//               A grant change only happens at an arbitration point: a
//               completed transfer (HREADY=1) that is not BUSY, finishes the
//               current burst (remaining beats = 0) and is not under a lock
//               hold by the granted manager.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int IDX_W          = 2
) (
  input  wire logic    i_HCLK,
  input  wire logic    i_HRESET,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] c_htrans_idle   = 2'd0;
  localparam logic [1:0] c_htrans_busy   = 2'd1;
  localparam logic [1:0] c_htrans_nonseq = 2'd2;
  localparam logic [1:0] c_htrans_seq    = 2'd3;

  localparam logic [IDX_W-1:0]     c_default_idx   = IDX_W'(DEFAULT_MASTER);
  localparam logic [N_MASTERS-1:0] c_one           = N_MASTERS'(1);
  localparam logic [N_MASTERS-1:0] c_default_grant = c_one << DEFAULT_MASTER;

  logic [N_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]     r_gidx;      // index of r_grant; doubles as round-robin pointer
  logic [IDX_W-1:0]     r_master;
  logic                 r_mastlock;
  logic [3:0]           r_cnt;       // beats still to come in the current burst

  logic [3:0]           w_cnt_n;
  logic                 w_lock_hold;
  logic                 w_arb_point;
  logic [IDX_W-1:0]     w_next_idx;
  logic                 w_found;
  logic [IDX_W-1:0]     w_scan_idx;

  // Remaining-beat count after the transfer completing on this edge.
  always_comb begin
    w_cnt_n = 4'd0;
    case (bus.i_HTRANS)
      c_htrans_nonseq: begin
        case (bus.i_HBURST)
          3'd2, 3'd3: w_cnt_n = 4'd3;
          3'd4, 3'd5: w_cnt_n = 4'd7;
          3'd6, 3'd7: w_cnt_n = 4'd15;
          default:    w_cnt_n = 4'd0;   // SINGLE / INCR: each beat may hand over
        endcase
      end
      c_htrans_seq:  w_cnt_n = (r_cnt != 4'd0) ? (r_cnt - 4'd1) : 4'd0;
      c_htrans_busy: w_cnt_n = r_cnt;
      c_htrans_idle: w_cnt_n = 4'd0;
      default:       w_cnt_n = 4'd0;
    endcase
  end

  // Only the granted manager's own request/lock can hold the bus.
  assign w_lock_hold = bus.i_HLOCK[r_gidx] & bus.i_HBUSREQ[r_gidx];

  assign w_arb_point = bus.i_HREADY
                     & (bus.i_HTRANS != c_htrans_busy)
                     & (w_cnt_n == 4'd0)
                     & ~w_lock_hold;

  // Scan g+1, g+2, ... ending at g itself; first requester wins.
  always_comb begin
    w_next_idx = c_default_idx;
    w_found    = 1'b0;
    w_scan_idx = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      w_scan_idx = IDX_W'((int'(r_gidx) + i) % N_MASTERS);
      if (!w_found && bus.i_HBUSREQ[w_scan_idx]) begin
        w_found    = 1'b1;
        w_next_idx = w_scan_idx;
      end
    end
  end

  always_ff @(posedge i_HCLK) begin
    if (i_HRESET) begin
      r_grant    <= c_default_grant;
      r_gidx     <= c_default_idx;
      r_master   <= c_default_idx;
      r_mastlock <= 1'b0;
      r_cnt      <= 4'd0;
    end else if (bus.i_HREADY) begin
      r_cnt      <= w_cnt_n;
      // Ownership and lock follow the grant that was in force for this transfer.
      r_master   <= r_gidx;
      r_mastlock <= bus.i_HLOCK[r_gidx];
      if (w_arb_point) begin
        r_gidx  <= w_next_idx;
        r_grant <= c_one << w_next_idx;
      end
    end
  end

  assign bus.o_HGRANT    = r_grant;
  assign bus.o_HMASTER   = r_master;
  assign bus.o_HMASTLOCK = r_mastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_arbiter
// Description : Self-checking bench for ahb_arbiter. Directed scenarios for
//               rotation, burst handover, stalls, locking, idle default and
//               reset, followed by randomized traffic. A reference model
//               predicts the registered outputs after each edge; a monitor
//               compares them one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;
  localparam int IW  = 2;

  typedef struct {
    logic [N-1:0]  grant;
    logic [IW-1:0] master;
    logic          lock;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // Reference model state (plain integers)
  int m_g, m_master, m_lock, m_cnt;
  int c_beats[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  ahb_arbiter_if #(.N_MASTERS(N), .IDX_W(IW)) bus ();

  ahb_arbiter #(
    .N_MASTERS     (N),
    .DEFAULT_MASTER(DEF),
    .IDX_W         (IW)
  ) dut (
    .i_HCLK  (clk),
    .i_HRESET(rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Round-robin choice by distance from the current owner: g+1 is nearest,
  // g itself is farthest.
  function automatic int pick(input int g, input logic [N-1:0] req);
    int best  = -1;
    int bestd = N;
    for (int m = 0; m < N; m++) begin
      if (req[m]) begin
        int d;
        d = (m - g - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = m;
        end
      end
    end
    return (best < 0) ? DEF : best;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] req, input logic [N-1:0] lk,
                            input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    exp_t e;
    if (r) begin
      m_g = DEF; m_master = DEF; m_lock = 0; m_cnt = 0;
    end else if (rdy) begin
      int  nc;
      bit  hold;
      int  ng;
      case (tr)
        2'd2:    nc = c_beats[bu] - 1;
        2'd3:    nc = (m_cnt > 0) ? m_cnt - 1 : 0;
        2'd1:    nc = m_cnt;
        default: nc = 0;
      endcase
      hold = lk[m_g] && req[m_g];
      ng   = m_g;
      if (tr != 2'd1 && nc == 0 && !hold) ng = pick(m_g, req);
      m_master = m_g;
      m_lock   = int'(lk[m_g]);
      m_cnt    = nc;
      m_g      = ng;
    end
    e.grant  = N'(1) << m_g;
    e.master = IW'(m_master);
    e.lock   = (m_lock != 0);
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [N-1:0] req, input logic [N-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    @(negedge clk);
    rst           = r;
    bus.i_HBUSREQ = req;
    bus.i_HLOCK   = lk;
    bus.i_HTRANS  = tr;
    bus.i_HBURST  = bu;
    bus.i_HREADY  = rdy;
    model_step(r, req, lk, tr, bu, rdy);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents registered outputs after every edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("grant",      int'(bus.o_HGRANT),      int'(e.grant));
        check("master",     int'(bus.o_HMASTER),     int'(e.master));
        check("mastlock",   int'(bus.o_HMASTLOCK),   int'(e.lock));
        check("onehot",     $countones(bus.o_HGRANT), 1);
      end
    end
  end

  initial begin : stim
    logic [1:0]   tr;
    logic [N-1:0] req, lk;
    int           sel;
    bus.i_HBUSREQ = '0;
    bus.i_HLOCK   = '0;
    bus.i_HTRANS  = 2'd0;
    bus.i_HBURST  = 3'd0;
    bus.i_HREADY  = 1'b1;

    // Reset state
    drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
    drive(1, 4'b1111, 4'b1111, 2'd2, 3'd5, 1);

    // Rotation among managers 1..3 with IDLE traffic
    for (int i = 0; i < 6; i++) drive(0, 4'b1110, 4'b0000, 2'd0, 3'd0, 1);

    // INCR4 burst by manager 1 while manager 2 waits
    drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
    drive(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1);
    drive(0, 4'b0110, 4'b0000, 2'd2, 3'd3, 1);
    for (int i = 0; i < 3; i++) drive(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1);
    drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1);
    drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1);

    // Same burst with two stall cycles and one BUSY beat
    drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
    drive(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1);
    drive(0, 4'b0110, 4'b0000, 2'd2, 3'd3, 1);
    drive(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 0);
    drive(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 0);
    drive(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1);
    drive(0, 4'b0110, 4'b0000, 2'd1, 3'd3, 1);
    drive(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1);
    drive(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1);
    drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1);

    // Manager 3 holds a lock against everyone else, then releases it
    drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
    drive(0, 4'b1000, 4'b1000, 2'd0, 3'd0, 1);
    for (int i = 0; i < 10; i++) drive(0, 4'b1111, 4'b1111, 2'd2, 3'd0, 1);
    drive(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1);
    drive(0, 4'b0111, 4'b0000, 2'd0, 3'd0, 1);

    // No requests: default manager, held
    for (int i = 0; i < 4; i++) drive(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);

    // Reset in the middle of a locked INCR8
    drive(0, 4'b0010, 4'b0010, 2'd0, 3'd0, 1);
    drive(0, 4'b0110, 4'b0010, 2'd2, 3'd5, 1);
    drive(0, 4'b0110, 4'b0010, 2'd3, 3'd5, 1);
    drive(0, 4'b0110, 4'b0010, 2'd3, 3'd5, 1);
    drive(1, 4'b0110, 4'b0010, 2'd3, 3'd5, 1);
    drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1);
    drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      tr  = (sel < 1) ? 2'd0 : (sel < 2) ? 2'd1 : (sel < 4) ? 2'd2 : 2'd3;
      req = N'($urandom);
      lk  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drive(($urandom_range(0, 99) == 0), req, lk, tr, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 4) != 0));
    end

    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
